message_fifo: RTL
=================

Name: message_fifo

Overview:
- Elastic buffer between the partial message counter and the DES unit.
- Captures every valid 64-bit counter message and presents it to the DES unit with a valid/ready handshake, in first-word-fall-through order.
- Drives the counter's pause input so no message is dropped while the DES unit stalls.
- Forwards the counter's region-done indication once every buffered message has been consumed.

Parameters:
- DEPTH, 8, number of 64-bit entries; must be a power of two, ≥4.
- AW, 3, pointer width, log2(DEPTH).
- SLACK, 2, free entries still available when pause_out is asserted; must be ≥2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  wired to the same source as the counter's reset_counter; empties the buffer.
- in_msg  in  64  message from the counter ({counter_bits, region}).
- in_valid  in  1  counter valid; no backpressure on this side.
- in_done  in  1  counter done (region exhausted).
- pause_out  out  1  to the counter's pause input.
- out_msg  out  64  head entry to the DES unit.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  DES unit accepts out_msg this cycle.
- drained  out  1  region complete: in_done seen and buffer empty.
- overflow  out  1  sticky error: a write was attempted while full.
- level  out  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset values (asynchronous): pointers 0, level 0, out_valid 0, pause_out 0, drained 0, overflow 0, state IDLE. out_msg is don't-care while out_valid=0; RAM contents are not reset.
- Write: when in_valid=1 and level<DEPTH, in_msg is stored at wr_ptr and wr_ptr increments.
- Write while full: when in_valid=1 and level=DEPTH, the data is dropped and overflow is set until rst or flush.
- Read: when out_valid=1 and out_ready=1, rd_ptr increments.
- Head presentation: out_msg is always the entry at rd_ptr; out_valid = (level≠0).
- Latency: a word written in cycle t appears on out_msg/out_valid in cycle t+1.
- Simultaneous read and write: allowed at any level, including full; level is unchanged.
- Pointers wrap modulo DEPTH.
- level_next = level + write − read.
- pause_out is registered: pause_out <= (level_next ≥ DEPTH−SLACK).
- Why SLACK ≥ 2: the counter keeps in_valid high for one more cycle after it sees pause (its next-state logic is registered). With pause_out itself registered, up to two further writes can arrive after the threshold is crossed.
- pause_out deasserts in the cycle after level_next drops below DEPTH−SLACK; there is no hysteresis.
- FSM states:
  - IDLE: waiting for traffic; goes to RUN on the first in_valid.
  - RUN: normal operation; goes to DRAIN when in_done=1.
  - DRAIN: in_done is latched; goes to DONE when level_next=0.
  - DONE: drained=1; stays in DONE until flush.
- FSM timing:
  - In_done arriving together with a write is handled: that write is kept and DRAIN waits for it to be read.
  - If in_done rises while level=0, the FSM goes to DRAIN and then to DONE on the next cycle.
- flush, synchronous and of highest priority:
  - Next cycle: level=0, pointers=0, out_valid=0, pause_out=0, overflow=0, state=IDLE.
  - A simultaneous in_valid is ignored, because the counter is also being reset.
- Reset mid-operation: all buffered data is discarded; no partial word is presented afterwards.
- in_valid during DONE (only possible through a protocol error) is written normally; the state stays DONE until flush.

Decomposition:
- Shared package des_pkg: MSG_W=64, the FSM state encoding for this block (2-bit: IDLE, RUN, DRAIN, DONE), and the region-width parameter N already used by the counter.
- One sub-module, fifo_mem: a DEPTH×64 register array with one write port and one combinational read port, no reset.
- Pointers, level, FSM and pause logic live in message_fifo.

Test Plan:
1. Pass-through: out_ready=1, in_msg=0x0000_0000_0000_0001..0x0000_0000_0000_0010 on consecutive cycles.
   - Required: each word appears one cycle later, in order.
   - Required: level ≤1, pause_out stays 0, overflow stays 0.
2. Stall, DEPTH=8: out_ready=0, continuous in_valid.
   - Required: pause_out=1 in the cycle after the 6th write.
   - Required: at most two further writes, final level ≤8, overflow=0.
   - Then out_ready=1: pause_out drops the cycle after level falls to 5, and all 8 words are read in order.
3. Full with simultaneous read/write: level=8, in_valid=1 and out_ready=1 in the same cycle.
   - Required: level stays 8, overflow=0, new word stored at the tail.
4. Region end: in_done rises while level=3, out_ready=1.
   - Required: drained=1 exactly one cycle after the third read, and it stays high.
   - Then flush: drained=0, level=0, state IDLE.
5. Overflow detection: force in_valid while level=8 and out_ready=0.
   - Required: overflow=1 sticky and level stays 8.
   - Required: overflow is cleared by flush, and asynchronously by rst=1 with no clock edge.
6. Reset mid-stream: assert rst asynchronously while level=5.
   - Required: out_valid=0, level=0, pause_out=0 immediately.
   - After release, the first new word 0xAAAA_0000_0000_1234 is output first.

Source files
------------

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared widths and state encoding for the DES datapath blocks
package des_pkg;

  // Counter message width: {counter_bits, region}
  localparam int MSG_W = 64;

  // Region width used by the partial message counter
  localparam int N = 16;

  // message_fifo region-tracking states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fifo_state_t;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x MSG_W register array, one write port, combinational read
module fifo_mem
  import des_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [MSG_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [MSG_W-1:0] rd_data
);

  logic [MSG_W-1:0] mem [DEPTH];

  // Storage is never reset; validity is tracked by the pointers in the parent
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/message_fifo.sv
// rtl/message_fifo.sv - FWFT elastic buffer between the message counter and the DES unit
module message_fifo
  import des_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int SLACK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [MSG_W-1:0] in_msg,
  input  logic             in_valid,
  input  logic             in_done,
  output logic             pause_out,
  output logic [MSG_W-1:0] out_msg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             drained,
  output logic             overflow,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] PAUSE_LVL = (AW+1)'(DEPTH - SLACK);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_next;
  logic          full;
  logic          do_rd;
  logic          do_wr;
  logic          mem_we;
  fifo_state_t   state;
  fifo_state_t   state_next;

  // A full buffer still accepts a write when the head leaves in the same cycle
  always_comb begin
    full       = (level == FULL_LVL);
    do_rd      = (level != '0) && out_ready;
    do_wr      = in_valid && (!full || do_rd);
    mem_we     = do_wr && !flush;
    level_next = level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr),
    .wr_data (in_msg),
    .rd_addr (rd_ptr),
    .rd_data (out_msg)
  );

  assign out_valid = (level != '0);
  assign drained   = (state == ST_DONE);

  // Pointers, occupancy, registered pause and sticky overflow; flush beats everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pause_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pause_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level     <= level_next;
      pause_out <= (level_next >= PAUSE_LVL);
      if (in_valid && full && !do_rd) begin
        overflow <= 1'b1;
      end
    end
  end

  // Region-tracking state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Region-tracking next state: DRAIN waits until the last buffered word is taken
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (in_valid)            state_next = ST_RUN;
      ST_RUN:   if (in_done)             state_next = ST_DRAIN;
      ST_DRAIN: if (level_next == '0)    state_next = ST_DONE;
      ST_DONE:                           state_next = ST_DONE;
      default:                           state_next = ST_IDLE;
    endcase
    if (flush) begin
      state_next = ST_IDLE;
    end
  end

endmodule
